fp_subtractor_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor (out = a - b). It is the inverse-operation companion to the team's combinational single-precision adder and uses the same arithmetic conventions: denormals take exponent 1 with hidden bit 0, and alignment and normalisation truncate with no rounding. Alignment and normalisation are serial, one bit per cycle, to save area. Operands enter and results leave over valid/ready handshakes, so the block sits between an operand sequencer and a result consumer in the ALU datapath.

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_serial_normaliser.sv | 43 ++++
 rtl/fp_subtractor_seq.sv | 146 ++++++++++++++
 tb/tb_fp_subtractor_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field layout, FSM states and operand unpack rule
// for the serial floating-point add/subtract datapaths.
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
  } unpacked_t;

  // Denormals take exponent 1 with a zero hidden bit.
  function automatic unpacked_t fp_unpack(input logic [31:0] f);
    unpacked_t u;
    u.exp = (f[MAN_W +: EXP_W] == '0) ? 8'd1 : f[MAN_W +: EXP_W];
    u.man = {(f[MAN_W +: EXP_W] != '0), f[MAN_W-1:0]};
    return u;
  endfunction
endpackage

// File: rtl/fp_serial_normaliser.sv
// One normalisation step: zero detect, carry right-shift, one-bit left-shift
// or final pack. Purely combinational so the adder path can reuse it.
module fp_serial_normaliser
  import fp_pkg::*;
(
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [MAN_W+1:0] i_man,
  output logic [EXP_W-1:0] o_exp,
  output logic [MAN_W+1:0] o_man,
  output logic             o_done,
  output logic [31:0]      o_word
);
  logic [EXP_W-1:0] w_exp_inc;
  logic [EXP_W-1:0] w_pack_exp;

  assign w_exp_inc  = i_exp + 8'd1;
  // Without the hidden bit the value is a denormal and packs with exponent 0.
  assign w_pack_exp = i_man[MAN_W] ? i_exp : {EXP_W{1'b0}};

  always_comb begin
    o_exp  = i_exp;
    o_man  = i_man;
    o_done = 1'b0;
    o_word = '0;
    if (i_man == '0) begin
      o_done = 1'b1;
    end else if (i_man[MAN_W+1]) begin
      o_man = i_man >> 1;
      o_exp = w_exp_inc;
      if (w_exp_inc == EXP_MAX) begin
        o_done = 1'b1;
        o_word = {i_sign, EXP_MAX, {MAN_W{1'b0}}};
      end
    end else if (!i_man[MAN_W] && (i_exp > 8'd1)) begin
      o_man = i_man << 1;
      o_exp = i_exp - 8'd1;
    end else begin
      o_done = 1'b1;
      o_word = {i_sign, w_pack_exp, i_man[MAN_W-1:0]};
    end
  end
endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle single-precision subtractor (out = a - b) with serial alignment
// and normalisation, truncating, behind valid/ready handshakes.
module fp_subtractor_seq
  import fp_pkg::*;
#(
  parameter int ALIGN_SAT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);
  localparam logic [EXP_W-1:0] SAT = EXP_W'(ALIGN_SAT);

  state_t           r_state, w_next;
  logic             r_sign_l, r_sign_s, r_sign;
  logic [EXP_W-1:0] r_exp, r_diff;
  logic [MAN_W:0]   r_man_l, r_man_s;
  logic [MAN_W+1:0] r_man;
  logic [31:0]      r_out;

  unpacked_t        w_ua, w_ub;
  logic             w_accept, w_special, w_swap, w_sat;
  logic [EXP_W-1:0] w_diff;
  logic             w_add_sign;
  logic [MAN_W+1:0] w_add_man;
  logic [EXP_W-1:0] w_norm_exp;
  logic [MAN_W+1:0] w_norm_man;
  logic             w_norm_done;
  logic [31:0]      w_norm_word;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out       = r_out;

  assign w_accept  = in_valid && in_ready;
  assign w_ua      = fp_unpack(a);
  assign w_ub      = fp_unpack(b);
  assign w_special = (a[30:23] == EXP_MAX) || (b[30:23] == EXP_MAX);
  assign w_swap    = (w_ub.exp > w_ua.exp);
  assign w_diff    = w_swap ? (w_ub.exp - w_ua.exp) : (w_ua.exp - w_ub.exp);
  assign w_sat     = (r_diff >= SAT);

  // Magnitude add/subtract; the result carries the sign of the larger operand.
  always_comb begin
    w_add_sign = r_sign_l;
    w_add_man  = {1'b0, r_man_l} + {1'b0, r_man_s};
    if (r_sign_l != r_sign_s) begin
      if (r_man_l >= r_man_s) begin
        w_add_man = {1'b0, r_man_l - r_man_s};
      end else begin
        w_add_man  = {1'b0, r_man_s - r_man_l};
        w_add_sign = r_sign_s;
      end
    end
  end

  fp_serial_normaliser u_norm (
    .i_sign (r_sign),
    .i_exp  (r_exp),
    .i_man  (r_man),
    .o_exp  (w_norm_exp),
    .o_man  (w_norm_man),
    .o_done (w_norm_done),
    .o_word (w_norm_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_special)           w_next = ST_DONE;
          else if (w_diff != '0)   w_next = ST_ALIGN;
          else                     w_next = ST_ADD;
        end
      end
      ST_ALIGN: if (w_sat || (r_diff == 8'd1)) w_next = ST_ADD;
      ST_ADD:   w_next = ST_NORM;
      ST_NORM:  if (w_norm_done) w_next = ST_DONE;
      ST_DONE:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign_l <= 1'b0;
      r_sign_s <= 1'b0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_diff   <= '0;
      r_man_l  <= '0;
      r_man_s  <= '0;
      r_man    <= '0;
      r_out    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_special) begin
              r_out <= QNAN;
            end else begin
              // b enters with its sign flipped, turning the subtract into an add.
              r_sign_l <= w_swap ? ~b[31] : a[31];
              r_sign_s <= w_swap ? a[31] : ~b[31];
              r_exp    <= w_swap ? w_ub.exp : w_ua.exp;
              r_man_l  <= w_swap ? w_ub.man : w_ua.man;
              r_man_s  <= w_swap ? w_ua.man : w_ub.man;
              r_diff   <= w_diff;
            end
          end
        end
        ST_ALIGN: begin
          if (w_sat) begin
            r_man_s <= '0;
            r_diff  <= '0;
          end else begin
            r_man_s <= r_man_s >> 1;
            r_diff  <= r_diff - 8'd1;
          end
        end
        ST_ADD: begin
          r_man  <= w_add_man;
          r_sign <= w_add_sign;
        end
        ST_NORM: begin
          r_man <= w_norm_man;
          r_exp <= w_norm_exp;
          if (w_norm_done) r_out <= w_norm_word;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Bench for fp_subtractor_seq: directed vector table, handshake/reset
// sequences, and random operands against an arithmetic reference model.
module tb_fp_subtractor_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] tb_a = '0;
  logic [31:0] tb_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] dut_out;

  int n_cmp  = 0;
  int n_fail = 0;

  fp_subtractor_seq #(.ALIGN_SAT(25)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (tb_a),
    .b         (tb_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dut_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference: value-level arithmetic on signed integers with truncating shifts.
  function automatic void model(input logic [31:0] ia, input logic [31:0] ib,
                                output logic [31:0] r, output int lat);
    int ea, eb, ma, mb, el, es, ml, ms, d, al, v, mag, e, sh;
    bit sa, sb, sl, ss, s;
    if (ia[30:23] == 8'hFF || ib[30:23] == 8'hFF) begin
      r = 32'h7FC00000; lat = 0; return;
    end
    ea = (ia[30:23] == 0) ? 1 : int'(ia[30:23]);
    eb = (ib[30:23] == 0) ? 1 : int'(ib[30:23]);
    ma = int'(ia[22:0]) + ((ia[30:23] == 0) ? 0 : (1 << 23));
    mb = int'(ib[22:0]) + ((ib[30:23] == 0) ? 0 : (1 << 23));
    sa = ia[31];
    sb = ~ib[31];
    if (eb > ea) begin el = eb; ml = mb; sl = sb; es = ea; ms = ma; ss = sa; end
    else         begin el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sb; end
    d  = el - es;
    al = (d == 0) ? 0 : ((d >= 25) ? 1 : d);
    ms = (d >= 25) ? 0 : (ms >> d);
    v  = (sl ? -ml : ml) + (ss ? -ms : ms);
    if (v == 0) begin
      r = 32'h0; lat = 2 + al; return;
    end
    s = (v < 0);
    mag = s ? -v : v;
    e = el;
    sh = 0;
    if (mag >= (1 << 24)) begin
      mag = mag >> 1; e++; sh = 1;
      if (e == 255) begin
        r = {s, 8'hFF, 23'h0}; lat = -1; return;
      end
    end
    while (mag < (1 << 23) && e > 1) begin
      mag = mag << 1; e--; sh++;
    end
    r = {s, (mag >= (1 << 23)) ? e[7:0] : 8'h00, mag[22:0]};
    lat = 2 + al + sh;
  endfunction

  task automatic send(input logic [31:0] ia, input logic [31:0] ib);
    @(negedge clk);
    tb_a = ia;
    tb_b = ib;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("out_valid timeout", {31'h0, out_valid}, 32'h1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] mres;
    int          mlat, lat;
    int          ea, eb;

    vt[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 3};
    vt[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 2};
    vt[2]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 3};
    vt[3]  = '{32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 26};
    vt[4]  = '{32'h4B800000, 32'h3F800000, 32'h4B800000, 26};
    vt[5]  = '{32'h4B800000, 32'h3F000000, 32'h4B800000, 3};
    vt[6]  = '{32'h7F800000, 32'h3F800000, 32'h7FC00000, -1};
    vt[7]  = '{32'h3F800000, 32'hFFC00000, 32'h7FC00000, -1};
    vt[8]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, -1};
    vt[9]  = '{32'h00000003, 32'h00000001, 32'h00000002, 2};
    vt[10] = '{32'h00800000, 32'h00000001, 32'h007FFFFF, 2};
    vt[11] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 4};

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", {31'h0, in_ready}, 32'h1);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset out", dut_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      send(vt[i].a, vt[i].b);
      wait_valid(lat);
      check($sformatf("vec%0d out", i), dut_out, vt[i].res);
      if (vt[i].lat >= 0) check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
      release_out();
      check($sformatf("vec%0d in_ready after", i), {31'h0, in_ready}, 32'h1);
    end

    // Consumer stalls in DONE while new operands are offered.
    send(32'h40400000, 32'h3F800000);
    wait_valid(lat);
    @(negedge clk);
    tb_a = 32'h3F800000;
    tb_b = 32'h3F800000;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d out", k), dut_out, 32'h40000000);
      check($sformatf("hold%0d in_ready", k), {31'h0, in_ready}, 32'h0);
      check($sformatf("hold%0d out_valid", k), {31'h0, out_valid}, 32'h1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    check("after done out_valid", {31'h0, out_valid}, 32'h0);
    check("after done out kept", dut_out, 32'h40000000);
    check("after done in_ready", {31'h0, in_ready}, 32'h1);

    // Asynchronous reset in the middle of a long normalisation.
    send(32'h3F800000, 32'h3F7FFFFF);
    repeat (7) @(posedge clk);
    #1;
    check("pre-reset in_ready", {31'h0, in_ready}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("async reset out_valid", {31'h0, out_valid}, 32'h0);
    check("async reset in_ready", {31'h0, in_ready}, 32'h1);
    check("async reset out", dut_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send(32'h40400000, 32'h3F800000);
    wait_valid(lat);
    check("post-reset out", dut_out, 32'h40000000);
    check("post-reset latency", 32'(lat), 32'd3);
    release_out();

    // Random operands with close and far exponents, both signs.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra, rb;
      ea = $urandom_range(0, 253);
      if (n % 3 == 0) eb = ea;
      else if (n % 3 == 1) eb = (ea + $urandom_range(0, 4) > 253) ? ea : ea + $urandom_range(0, 4);
      else eb = $urandom_range(0, 253);
      ra = {1'($urandom), 8'(ea), 23'($urandom)};
      rb = {1'($urandom), 8'(eb), 23'($urandom)};
      if (n % 2 == 1) begin
        logic [31:0] t;
        t = ra; ra = rb; rb = t;
      end
      if (n % 10 == 5) rb = {~ra[31], ra[30:23], ra[22:4], 4'($urandom)};
      model(ra, rb, mres, mlat);
      send(ra, rb);
      wait_valid(lat);
      check($sformatf("rand%0d %h-%h out", n, ra, rb), dut_out, mres);
      if (mlat >= 0) check($sformatf("rand%0d latency", n), 32'(lat), 32'(mlat));
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
